mem_port_arbiter: RTL and testbench
===================================

# mem_port_arbiter

Shares the CPU's single memory port between three requesters: load/store, instruction fetch and DMA. The load/store requester is driven by the MEM stage and the fetch requester by the IF stage of the multicycle controller. The block arbitrates among them, issues one access at a time to the memory, waits on the memory's `mem_ready`, and returns a one-cycle completion pulse to the winning requester. It sits between the stage sequencer/datapath and the memory, and it lets DMA traffic progress without stalling the core indefinitely.

## Interface
- `AW`, 16, address width
- `DW`, 16, data width
- `STARVE_LIMIT`, 4, lost arbitrations after which DMA is promoted; must be ≥1
- `TIMEOUT`, 15, BUSY cycles without `mem_ready` before abort; used only with `MEM_ARB_TIMEOUT_EN`

Ports:
- `clk`  in  1  single clock; all logic on rising edge
- `reset`  in  1  synchronous, active-high reset
- `ls_req`  in  1  load/store request, level
- `ls_we`  in  1  1 = write
- `ls_addr`  in  AW  load/store address
- `ls_wdata`  in  DW  load/store write data
- `ls_done`  out  1  load/store completion pulse
- `if_req`  in  1  fetch request, read only
- `if_addr`  in  AW  fetch address
- `if_done`  out  1  fetch completion pulse
- `dma_req`  in  1  DMA request, level
- `dma_we`  in  1  1 = write
- `dma_addr`  in  AW  DMA address
- `dma_wdata`  in  DW  DMA write data
- `dma_done`  out  1  DMA completion pulse
- `rdata`  out  DW  read data; valid while any `*_done` is high
- `busy`  out  1  high in BUSY and RESP
- `err`  out  1  timeout abort flag; tied 0 without the macro
- `mem_req`  out  1  memory access strobe
- `mem_we`  out  1  memory write enable
- `mem_addr`  out  AW  memory address
- `mem_wdata`  out  DW  memory write data
- `mem_rdata`  in  DW  memory read data; valid with `mem_ready`
- `mem_ready`  in  1  memory completion

## Operation
- FSM states: IDLE, BUSY, RESP.
- **IDLE**
  - If any request is present, choose the winner and latch its id, `we`, `addr` and `wdata` (for fetch, `we` = 0 and `wdata` = 0).
  - Then go to BUSY.
- **Priority**
  - Default order: ls > if > dma.
  - If `starve_cnt == STARVE_LIMIT` and `dma_req` is high, DMA wins regardless of the other requests.
- **starve_cnt**
  - Increments, saturating at `STARVE_LIMIT`, on each IDLE arbitration where `dma_req` = 1 and DMA loses.
  - Clears on a DMA grant, or in any cycle where `dma_req` = 0.
- **BUSY**
  - `mem_req` = 1; `mem_we`, `mem_addr` and `mem_wdata` come from the latched values and are held stable.
  - When `mem_ready` = 1: capture `mem_rdata` into `rdata` (writes also capture, so the value is don't-care to the requester), then go to RESP.
- **RESP**
  - `mem_req` = 0; the winner's `*_done` = 1 for exactly one cycle.
  - Next state is IDLE.
- **Requester rules**
  - Hold `req` and operands stable from assertion until `*_done`.
  - Drop `req` (or present the next request) by the clock edge that ends the `*_done` cycle.
  - Changing a request's operands while it is pending or in service is illegal.
- Only the latched requester's `*_done` may assert. At most one `*_done` is high in any cycle.
- A request that appears while BUSY or RESP waits for the next IDLE cycle.

## Timing
- **Reset**
  - State goes to IDLE. All outputs are 0: `mem_req`, `mem_we`, `mem_addr`, `mem_wdata`, `rdata`, every `*_done`, `busy`, `err`. `starve_cnt` = 0.
  - Reset mid-access aborts the access: no `*_done` is issued, and `mem_req` is low in the cycle after reset is sampled.
- **Minimum latency**
  - Request seen in IDLE at cycle N; `mem_req` high at N+1.
  - If `mem_ready` is high at N+1, `*_done` and `rdata` are valid at N+2, and IDLE is back at N+3.
  - Back-to-back accesses take 3 cycles each.
- **Wait states:** each cycle of `mem_ready` = 0 in BUSY adds one cycle of latency.
- `mem_ready` is ignored outside BUSY.
- All outputs are registered.

## Configuration
- **`MEM_ARB_TIMEOUT_EN` defined**
  - A BUSY cycle counter clears on entry to BUSY.
  - If `TIMEOUT` consecutive BUSY cycles pass without `mem_ready`, go to RESP with `rdata` = 0 and `err` = 1 coincident with `*_done`.
  - `mem_ready` arriving in the same cycle as expiry counts as success.
- **Undefined:** BUSY waits indefinitely, and `err` is constant 0.

## Test plan
- **Single access:** `ls_req`, read, addr 0x0010, `mem_ready` immediate, `mem_rdata` = 0xBEEF → `mem_req` at N+1; `ls_done` = 1 with `rdata` = 0xBEEF at N+2; `busy` low at N+3.
- **Simultaneous requests:** `ls_req`, `if_req` and `dma_req` all asserted, each dropped after its done → served in order ls, if, dma; done pulses at N+2, N+5, N+8.
- **DMA starvation:** `ls_req` held continuously with back-to-back re-requests, `dma_req` held, `STARVE_LIMIT` = 4 → after 4 ls grants, the 5th arbitration grants DMA; `starve_cnt` returns to 0.
- **Wait states:** write, `ls_we` = 1, addr 0x0020, `wdata` = 0x1234, `mem_ready` delayed 3 cycles → `mem_req`/`mem_we`/`mem_addr`/`mem_wdata` stable for 4 cycles; `ls_done` one cycle after `mem_ready`.
- **Reset mid-access:** `reset` asserted in BUSY → no done pulse; `mem_req` = 0 in the cycle after reset is sampled; all outputs 0.
- **Timeout (macro on, `TIMEOUT` = 15):** `mem_ready` never asserted → `if_done` = 1, `err` = 1 and `rdata` = 0 exactly 16 cycles after `mem_req` first rises.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port between load/store, fetch and DMA.
// Fixed priority ls > if > dma, with DMA promoted after STARVE_LIMIT lost
// arbitrations. One access in flight; every output is a flop.
// Optional macro MEM_ARB_TIMEOUT_EN: abort a BUSY access after TIMEOUT cycles
// without mem_ready and flag it on err.
module mem_port_arbiter #(
  parameter int AW           = 16,
  parameter int DW           = 16,
  parameter int STARVE_LIMIT = 4,
  parameter int TIMEOUT      = 15
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          ls_req,
  input  logic          ls_we,
  input  logic [AW-1:0] ls_addr,
  input  logic [DW-1:0] ls_wdata,
  output logic          ls_done,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic          if_done,
  input  logic          dma_req,
  input  logic          dma_we,
  input  logic [AW-1:0] dma_addr,
  input  logic [DW-1:0] dma_wdata,
  output logic          dma_done,
  output logic [DW-1:0] rdata,
  output logic          busy,
  output logic          err,
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  input  logic          mem_ready
);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_RESP} state_t;
  typedef enum logic [1:0] {G_LS, G_IF, G_DMA} gnt_t;

  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

  state_t        state_q, state_d;
  gnt_t          gnt_q, gnt_d;
  logic [SW-1:0] starve_cnt_q, starve_cnt_d;
  logic          mem_req_q, mem_req_d;
  logic          mem_we_q, mem_we_d;
  logic [AW-1:0] mem_addr_q, mem_addr_d;
  logic [DW-1:0] mem_wdata_q, mem_wdata_d;
  logic [DW-1:0] rdata_q, rdata_d;
  logic [2:0]    done_q, done_d;   // {dma, if, ls}
  logic          busy_q, busy_d;

`ifdef MEM_ARB_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TMO_MAX = TW'(TIMEOUT);
  logic [TW-1:0] tmo_cnt_q, tmo_cnt_d;
  logic          err_q, err_d;
`endif

  // Next-state, arbitration, operand latching and registered-output values
  always_comb begin
    state_d      = state_q;
    gnt_d        = gnt_q;
    starve_cnt_d = dma_req ? starve_cnt_q : '0;
    mem_req_d    = mem_req_q;
    mem_we_d     = mem_we_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    rdata_d      = rdata_q;
    done_d       = 3'b000;
    busy_d       = busy_q;
`ifdef MEM_ARB_TIMEOUT_EN
    tmo_cnt_d    = tmo_cnt_q;
    err_d        = err_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (ls_req || if_req || dma_req) begin
          if (dma_req && starve_cnt_q == STARVE_MAX) gnt_d = G_DMA;
          else if (ls_req)                           gnt_d = G_LS;
          else if (if_req)                           gnt_d = G_IF;
          else                                       gnt_d = G_DMA;
          case (gnt_d)
            G_LS: begin
              mem_we_d = ls_we; mem_addr_d = ls_addr; mem_wdata_d = ls_wdata;
            end
            G_IF: begin
              mem_we_d = 1'b0; mem_addr_d = if_addr; mem_wdata_d = '0;
            end
            default: begin
              mem_we_d = dma_we; mem_addr_d = dma_addr; mem_wdata_d = dma_wdata;
            end
          endcase
          // DMA lost this round: age it, saturating at the promotion point
          if (gnt_d == G_DMA)                          starve_cnt_d = '0;
          else if (dma_req && starve_cnt_q != STARVE_MAX) starve_cnt_d = starve_cnt_q + 1'b1;
          state_d   = S_BUSY;
          mem_req_d = 1'b1;
          busy_d    = 1'b1;
`ifdef MEM_ARB_TIMEOUT_EN
          tmo_cnt_d = '0;
`endif
        end
      end
      S_BUSY: begin
        if (mem_ready) begin
          rdata_d        = mem_rdata;
          state_d        = S_RESP;
          mem_req_d      = 1'b0;
          done_d[gnt_q]  = 1'b1;
        end
`ifdef MEM_ARB_TIMEOUT_EN
        else if (tmo_cnt_q == TMO_MAX) begin
          rdata_d        = '0;
          err_d          = 1'b1;
          state_d        = S_RESP;
          mem_req_d      = 1'b0;
          done_d[gnt_q]  = 1'b1;
        end else begin
          tmo_cnt_d = tmo_cnt_q + 1'b1;
        end
`endif
      end
      S_RESP: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
`ifdef MEM_ARB_TIMEOUT_EN
        err_d   = 1'b0;
`endif
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and output registers; reset aborts any access in flight
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      gnt_q        <= G_LS;
      starve_cnt_q <= '0;
      mem_req_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      rdata_q      <= '0;
      done_q       <= 3'b000;
      busy_q       <= 1'b0;
`ifdef MEM_ARB_TIMEOUT_EN
      tmo_cnt_q    <= '0;
      err_q        <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      gnt_q        <= gnt_d;
      starve_cnt_q <= starve_cnt_d;
      mem_req_q    <= mem_req_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      rdata_q      <= rdata_d;
      done_q       <= done_d;
      busy_q       <= busy_d;
`ifdef MEM_ARB_TIMEOUT_EN
      tmo_cnt_q    <= tmo_cnt_d;
      err_q        <= err_d;
`endif
    end
  end

  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign rdata     = rdata_q;
  assign ls_done   = done_q[G_LS];
  assign if_done   = done_q[G_IF];
  assign dma_done  = done_q[G_DMA];
  assign busy      = busy_q;
`ifdef MEM_ARB_TIMEOUT_EN
  assign err       = err_q;
`else
  assign err       = 1'b0;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: reset, single access, priority order,
// DMA promotion, wait states, optional timeout, reset mid-access.
module tb_mem_port_arbiter;
  localparam int AW = 16;
  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          reset;
  logic          ls_req, ls_we, if_req, dma_req, dma_we;
  logic [AW-1:0] ls_addr, if_addr, dma_addr;
  logic [DW-1:0] ls_wdata, dma_wdata;
  logic          ls_done, if_done, dma_done;
  logic [DW-1:0] rdata;
  logic          busy, err;
  logic          mem_req, mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;
  logic          mem_ready;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.AW(AW), .DW(DW), .STARVE_LIMIT(4), .TIMEOUT(15)) dut (
    .clk(clk), .reset(reset),
    .ls_req(ls_req), .ls_we(ls_we), .ls_addr(ls_addr), .ls_wdata(ls_wdata), .ls_done(ls_done),
    .if_req(if_req), .if_addr(if_addr), .if_done(if_done),
    .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
    .dma_done(dma_done),
    .rdata(rdata), .busy(busy), .err(err),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready)
  );

  // Advance one cycle; drives and samples happen 1 time unit after the edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    logic [15:0] exp_addr;
    logic [2:0]  exp_done;
    reset = 1'b1;
    ls_req = 0; ls_we = 0; ls_addr = '0; ls_wdata = '0;
    if_req = 0; if_addr = '0;
    dma_req = 0; dma_we = 0; dma_addr = '0; dma_wdata = '0;
    mem_rdata = '0; mem_ready = 0;
    tick(); tick();

    // Reset state
    chk("rst_mem_req", mem_req, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", {ls_done, if_done, dma_done}, 0);
    chk("rst_rdata", rdata, 0);
    chk("rst_err", err, 0);
    chk("rst_mem_addr", {mem_we, mem_addr, mem_wdata}, 0);
    reset = 1'b0;
    tick();

    // Single read, memory ready immediately
    ls_req = 1; ls_we = 0; ls_addr = 16'h0010; mem_rdata = 16'hBEEF; mem_ready = 1;
    tick();
    chk("t1_mem_req", mem_req, 1);
    chk("t1_mem_addr", mem_addr, 16'h0010);
    chk("t1_mem_we", mem_we, 0);
    chk("t1_busy", busy, 1);
    chk("t1_no_done", ls_done, 0);
    tick();
    chk("t1_ls_done", {ls_done, if_done, dma_done}, 3'b100);
    chk("t1_rdata", rdata, 16'hBEEF);
    chk("t1_mem_req_low", mem_req, 0);
    ls_req = 0;
    tick();
    chk("t1_busy_low", busy, 0);
    chk("t1_done_low", ls_done, 0);

    // Simultaneous requests: ls, then if, then dma
    mem_rdata = 16'hA5A5;
    ls_req = 1; ls_addr = 16'h0100;
    if_req = 1; if_addr = 16'h0200;
    dma_req = 1; dma_we = 0; dma_addr = 16'h0300;
    for (int g = 0; g < 3; g++) begin
      exp_addr = (g == 0) ? 16'h0100 : (g == 1) ? 16'h0200 : 16'h0300;
      exp_done = 3'b100 >> g;
      tick();
      chk($sformatf("t2_addr_%0d", g), mem_addr, exp_addr);
      tick();
      chk($sformatf("t2_done_%0d", g), {ls_done, if_done, dma_done}, exp_done);
      if (g == 0) ls_req = 0;
      else if (g == 1) if_req = 0;
      else dma_req = 0;
      tick();
      chk($sformatf("t2_idle_%0d", g), busy, 0);
    end

    // DMA promotion after four lost arbitrations, then counter restarts
    ls_req = 1; ls_addr = 16'h0400;
    dma_req = 1; dma_addr = 16'h0500;
    for (int g = 0; g < 6; g++) begin
      exp_addr = (g == 4) ? 16'h0500 : 16'h0400;
      exp_done = (g == 4) ? 3'b001 : 3'b100;
      tick();
      chk($sformatf("t3_addr_%0d", g), mem_addr, exp_addr);
      tick();
      chk($sformatf("t3_done_%0d", g), {ls_done, if_done, dma_done}, exp_done);
      if (g == 5) begin ls_req = 0; dma_req = 0; end
      tick();
    end

    // Write with three wait states: port held stable for four cycles
    ls_req = 1; ls_we = 1; ls_addr = 16'h0020; ls_wdata = 16'h1234; mem_ready = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (i == 3) mem_ready = 1;
      chk($sformatf("t4_port_%0d", i), {mem_req, mem_we, mem_addr, mem_wdata},
          {1'b1, 1'b1, 16'h0020, 16'h1234});
      chk($sformatf("t4_nodone_%0d", i), ls_done, 0);
    end
    tick();
    chk("t4_ls_done", {ls_done, if_done, dma_done}, 3'b100);
    chk("t4_mem_req_low", mem_req, 0);
    ls_req = 0; ls_we = 0; mem_ready = 0;
    tick();

`ifdef MEM_ARB_TIMEOUT_EN
    // Fetch never answered: abort 16 cycles after mem_req rises
    if_req = 1; if_addr = 16'h0050;
    tick();
    chk("t6_mem_req", mem_req, 1);
    for (int k = 1; k < 16; k++) begin
      tick();
      chk($sformatf("t6_wait_%0d", k), {if_done, err}, 2'b00);
    end
    tick();
    chk("t6_if_done", {ls_done, if_done, dma_done}, 3'b010);
    chk("t6_err", err, 1);
    chk("t6_rdata", rdata, 0);
    if_req = 0;
    tick();
    chk("t6_err_clear", err, 0);
`endif

    // Reset in the middle of a DMA access
    dma_req = 1; dma_we = 1; dma_addr = 16'h0040; dma_wdata = 16'h5678; mem_ready = 0;
    tick();
    chk("t5_mem_req", mem_req, 1);
    tick();
    reset = 1;
    tick();
    chk("t5_mem_req_low", mem_req, 0);
    chk("t5_outs_zero", {mem_we, mem_addr, mem_wdata, rdata, busy, err}, 0);
    chk("t5_no_done", {ls_done, if_done, dma_done}, 0);
    reset = 0; dma_req = 0; mem_ready = 1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("t5_quiet_%0d", i), {dma_done, mem_req, busy}, 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
